command_word_decoder: RTL and testbench
=======================================

# command_word_decoder

Synchronous front end of the 8259A PIC. It accepts byte writes from the read/write bus logic and runs the ICW1–ICW4 initialization sequence. After initialization it decodes OCW1/OCW2/OCW3 and holds the resulting mode and mask registers. It feeds the priority resolver's `LTIM`, `IM`, `operation` and `AEOI` inputs, plus the read-select, poll and cascade configuration used by the rest of the device.

## Interface
- No parameters.
- `clk` input 1: single system clock; all state changes on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `wr_stb` input 1: write strobe; each cycle it is sampled high is one write.
- `a0` input 1: address bit A0 of the write.
- `din` input 8: write data byte.
- `LTIM` output 1: level-triggered mode (ICW1 D3).
- `ADI` output 1: call-address interval (ICW1 D2).
- `SNGL` output 1: single mode (ICW1 D1).
- `IC4` output 1: ICW4 needed (ICW1 D0).
- `vec_base` output 5: T7–T3 (ICW2 D7:D3).
- `icw3` output 8: cascade byte.
- `SFNM`, `BUF`, `MS`, `AEOI`, `UPM` output 1 each: ICW4 D4..D0.
- `IM` output 8: interrupt mask (OCW1).
- `operation` output 8: last OCW2 byte.
- `ocw2_stb` output 1: one-cycle pulse when OCW2 is accepted.
- `read_isr` output 1: status read select; 0 = IRR, 1 = ISR.
- `smm` output 1: special mask mode.
- `poll_stb` output 1: one-cycle pulse on OCW3 with P=1.
- `init_done` output 1: high in READY.

## Operation
- Write classification, tested in this order:
  - ICW1: `a0`=0 and `din[4]`=1.
  - OCW2: `a0`=0, `din[4:3]`=00.
  - OCW3: `a0`=0, `din[4:3]`=01.
  - `a0`=1: ICW2, ICW3 or ICW4 during init, per state; OCW1 in READY.
- FSM states: WAIT_ICW1, WAIT_ICW2, WAIT_ICW3, WAIT_ICW4, READY.
- Transitions:
  - ICW1 from any state goes to WAIT_ICW2.
  - In WAIT_ICW2, an `a0`=1 write goes to WAIT_ICW3 if SNGL=0, else to WAIT_ICW4 if IC4=1, else to READY. SNGL and IC4 are the values just latched by ICW1.
  - In WAIT_ICW3, an `a0`=1 write goes to WAIT_ICW4 if IC4=1, else to READY.
  - In WAIT_ICW4, an `a0`=1 write goes to READY.
- Ignored writes:
  - In WAIT_ICW1, every write except ICW1 is ignored.
  - In WAIT_ICW2–4, `a0`=0 writes that are not ICW1 are ignored. State and registers stay unchanged.
- ICW1 side effects, same edge:
  - Latch LTIM, ADI, SNGL and IC4.
  - Clear `IM`, `operation`, `smm` and `read_isr`.
  - Clear `icw3` and `vec_base`.
  - If D0=0, also clear SFNM, BUF, MS, AEOI and UPM.
- ICW2 loads `vec_base` = `din[7:3]`. ICW3 loads `icw3` = `din`. ICW4 loads the five mode bits from `din[4:0]`.
- In READY:
  - OCW1 loads `IM` = `din`.
  - OCW2 loads `operation` = `din` and pulses `ocw2_stb`. A repeated identical EOI therefore still produces a strobe.
  - OCW3 updates `smm` = `din[5]` only when `din[6]`=1. It updates `read_isr` = `din[0]` only when `din[1]`=1. It pulses `poll_stb` when `din[2]`=1.
- OCW writes in READY never change the FSM state.
- Strobes (`ocw2_stb`, `poll_stb`) are high for exactly one cycle per accepted write. Back-to-back accepted writes give back-to-back pulses.

## Timing
- All outputs are registered. An accepted write on edge N is visible after edge N; latency is 1 cycle.
- Reset values (after any `rst`-high edge):
  - State: WAIT_ICW1.
  - All outputs 0, including `IM`=0x00, `operation`=0x00, `init_done`=0 and both strobes 0.
- `rst` has priority over `wr_stb` on the same edge. Reset mid-sequence abandons the sequence.
- `init_done` rises on the edge that enters READY. It falls on the edge accepting ICW1.
- ICW1 received mid-sequence restarts the sequence. Earlier partial ICW2–4 values are overwritten or cleared as listed above.

## Test plan
- Reset, then ICW1=0x13, ICW2=0x20, ICW4=0x03 -> LTIM=0, SNGL=1, IC4=1, `vec_base`=0x04, AEOI=1, UPM=1. `init_done`=1 one cycle after the ICW4 write; WAIT_ICW3 is skipped.
- ICW1=0x18, ICW2=0x40, ICW3=0x04 -> after the ICW3 write: state READY, ICW4 bits all 0, LTIM=1, `icw3`=0x04.
- In READY: OCW1 (`a0`=1, 0xA5) -> `IM`=0xA5. Then OCW2=0x20 twice -> `operation`=0x20 and two separate one-cycle `ocw2_stb` pulses.
- OCW3=0x0B -> `read_isr`=1, `smm` unchanged. Then OCW3=0x6C -> `smm`=1, one-cycle `poll_stb`, `read_isr` still 1.
- Before any ICW1, write `a0`=1 0xFF and OCW2=0x20 -> `IM`=0x00, `operation`=0x00, no strobes, state WAIT_ICW1.
- After ICW1 and ICW2, assert `rst` in the same cycle as an ICW3 write -> all outputs 0 and state WAIT_ICW1. A following `a0`=1 write is ignored.

Source files
------------

// File: rtl/command_word_decoder.sv
// 8259A command word front end: runs the ICW1..ICW4 init sequence, then decodes OCW1..OCW3
// into the mode, mask and strobe outputs used by the rest of the PIC.
module command_word_decoder (
    input  logic       clk,
    input  logic       rst,
    input  logic       wr_stb,
    input  logic       a0,
    input  logic [7:0] din,
    output logic       LTIM,
    output logic       ADI,
    output logic       SNGL,
    output logic       IC4,
    output logic [4:0] vec_base,
    output logic [7:0] icw3,
    output logic       SFNM,
    output logic       BUF,
    output logic       MS,
    output logic       AEOI,
    output logic       UPM,
    output logic [7:0] IM,
    output logic [7:0] operation,
    output logic       ocw2_stb,
    output logic       read_isr,
    output logic       smm,
    output logic       poll_stb,
    output logic       init_done
);

    localparam logic [2:0] WAIT_ICW1 = 3'd0;
    localparam logic [2:0] WAIT_ICW2 = 3'd1;
    localparam logic [2:0] WAIT_ICW3 = 3'd2;
    localparam logic [2:0] WAIT_ICW4 = 3'd3;
    localparam logic [2:0] READY     = 3'd4;

    logic [2:0] state;
    logic       is_icw1;
    logic       is_ocw2;
    logic       is_ocw3;

    // ICW1 wins over the OCW decodes; din[4:3]=11 with a0=0 is therefore always ICW1.
    always_comb begin
        is_icw1 = !a0 && din[4];
        is_ocw2 = !a0 && (din[4:3] == 2'b00);
        is_ocw3 = !a0 && (din[4:3] == 2'b01);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= WAIT_ICW1;
            LTIM      <= 1'b0;
            ADI       <= 1'b0;
            SNGL      <= 1'b0;
            IC4       <= 1'b0;
            vec_base  <= 5'd0;
            icw3      <= 8'd0;
            SFNM      <= 1'b0;
            BUF       <= 1'b0;
            MS        <= 1'b0;
            AEOI      <= 1'b0;
            UPM       <= 1'b0;
            IM        <= 8'd0;
            operation <= 8'd0;
            ocw2_stb  <= 1'b0;
            read_isr  <= 1'b0;
            smm       <= 1'b0;
            poll_stb  <= 1'b0;
            init_done <= 1'b0;
        end else begin
            ocw2_stb <= 1'b0;
            poll_stb <= 1'b0;
            if (wr_stb) begin
                if (is_icw1) begin
                    state     <= WAIT_ICW2;
                    init_done <= 1'b0;
                    LTIM      <= din[3];
                    ADI       <= din[2];
                    SNGL      <= din[1];
                    IC4       <= din[0];
                    vec_base  <= 5'd0;
                    icw3      <= 8'd0;
                    IM        <= 8'd0;
                    operation <= 8'd0;
                    smm       <= 1'b0;
                    read_isr  <= 1'b0;
                    // ICW4 bits survive a restart only when ICW4 will be rewritten anyway.
                    if (!din[0]) begin
                        SFNM <= 1'b0;
                        BUF  <= 1'b0;
                        MS   <= 1'b0;
                        AEOI <= 1'b0;
                        UPM  <= 1'b0;
                    end
                end else begin
                    case (state)
                        WAIT_ICW2: if (a0) begin
                            vec_base <= din[7:3];
                            if (!SNGL) begin
                                state <= WAIT_ICW3;
                            end else if (IC4) begin
                                state <= WAIT_ICW4;
                            end else begin
                                state     <= READY;
                                init_done <= 1'b1;
                            end
                        end
                        WAIT_ICW3: if (a0) begin
                            icw3 <= din;
                            if (IC4) begin
                                state <= WAIT_ICW4;
                            end else begin
                                state     <= READY;
                                init_done <= 1'b1;
                            end
                        end
                        WAIT_ICW4: if (a0) begin
                            SFNM      <= din[4];
                            BUF       <= din[3];
                            MS        <= din[2];
                            AEOI      <= din[1];
                            UPM       <= din[0];
                            state     <= READY;
                            init_done <= 1'b1;
                        end
                        READY: begin
                            if (a0) begin
                                IM <= din;
                            end else if (is_ocw2) begin
                                operation <= din;
                                ocw2_stb  <= 1'b1;
                            end else if (is_ocw3) begin
                                if (din[6]) smm <= din[5];
                                if (din[1]) read_isr <= din[0];
                                if (din[2]) poll_stb <= 1'b1;
                            end
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_command_word_decoder.sv
// Directed bench for command_word_decoder: a queue-based init-sequence model is compared
// against every output on every cycle, plus literal spot checks from hand-worked vectors.
module tb_command_word_decoder;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       wr_stb = 1'b0;
    logic       a0 = 1'b0;
    logic [7:0] din = 8'd0;
    logic       LTIM, ADI, SNGL, IC4, SFNM, BUF, MS, AEOI, UPM;
    logic [4:0] vec_base;
    logic [7:0] icw3, IM, operation;
    logic       ocw2_stb, read_isr, smm, poll_stb, init_done;

    int checks = 0;
    int failures = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    command_word_decoder dut (
        .clk(clk), .rst(rst), .wr_stb(wr_stb), .a0(a0), .din(din),
        .LTIM(LTIM), .ADI(ADI), .SNGL(SNGL), .IC4(IC4),
        .vec_base(vec_base), .icw3(icw3),
        .SFNM(SFNM), .BUF(BUF), .MS(MS), .AEOI(AEOI), .UPM(UPM),
        .IM(IM), .operation(operation), .ocw2_stb(ocw2_stb),
        .read_isr(read_isr), .smm(smm), .poll_stb(poll_stb), .init_done(init_done)
    );

    // Model: an init sequence is a list of still-expected a0=1 words; READY means started and list empty.
    bit       m_started;
    int       m_pend[$];
    bit [3:0] m_icw1;
    bit [4:0] m_vb;
    bit [7:0] m_icw3;
    bit [4:0] m_mode;
    bit [7:0] m_im, m_op;
    bit       m_ocw2, m_poll, m_risr, m_smm;

    function automatic logic [42:0] model_vec();
        bit done;
        done = m_started && (m_pend.size() == 0);
        return {m_icw1, m_vb, m_icw3, m_mode, m_im, m_op, m_ocw2, m_risr, m_smm, m_poll, done};
    endfunction

    logic [42:0] dut_vec;
    assign dut_vec = {LTIM, ADI, SNGL, IC4, vec_base, icw3, SFNM, BUF, MS, AEOI, UPM,
                      IM, operation, ocw2_stb, read_isr, smm, poll_stb, init_done};

    task automatic model_step(input bit r, input bit w, input bit a, input bit [7:0] d);
        int k;
        m_ocw2 = 0;
        m_poll = 0;
        if (r) begin
            m_started = 0; m_pend.delete();
            m_icw1 = 0; m_vb = 0; m_icw3 = 0; m_mode = 0;
            m_im = 0; m_op = 0; m_risr = 0; m_smm = 0;
        end else if (w) begin
            if (!a && d[4]) begin
                m_started = 1;
                m_icw1 = d[3:0];
                m_vb = 0; m_icw3 = 0; m_im = 0; m_op = 0; m_risr = 0; m_smm = 0;
                if (!d[0]) m_mode = 0;
                m_pend.delete();
                m_pend.push_back(2);
                if (!d[1]) m_pend.push_back(3);
                if (d[0]) m_pend.push_back(4);
            end else if (!m_started) begin
                // nothing is accepted before the first ICW1
            end else if (m_pend.size() > 0) begin
                if (a) begin
                    k = m_pend.pop_front();
                    if (k == 2) m_vb = d[7:3];
                    else if (k == 3) m_icw3 = d;
                    else m_mode = d[4:0];
                end
            end else if (a) begin
                m_im = d;
            end else if (d[4:3] == 2'b00) begin
                m_op = d;
                m_ocw2 = 1;
            end else begin
                if (d[6]) m_smm = d[5];
                if (d[1]) m_risr = d[0];
                if (d[2]) m_poll = 1;
            end
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            checks++;
            if (dut_vec !== model_vec()) begin
                failures++;
                $display("FAIL outputs t=%0t got=%h exp=%h", $time, dut_vec, model_vec());
            end
        end
    end

    task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    // Called at a falling edge; drives one cycle and returns at the next falling edge.
    task automatic cyc(input bit r, input bit w, input bit a, input bit [7:0] d);
        rst = r; wr_stb = w; a0 = a; din = d;
        @(posedge clk);
        model_step(r, w, a, d);
        @(negedge clk);
        rst = 0; wr_stb = 0; a0 = 0; din = 0;
    endtask

    task automatic wr(input bit a, input bit [7:0] d);
        cyc(1'b0, 1'b1, a, d);
    endtask

    task automatic idle();
        cyc(1'b0, 1'b0, 1'b0, 8'h00);
    endtask

    initial begin
        @(negedge clk);
        cyc(1'b1, 1'b0, 1'b0, 8'h00);
        chk_en = 1'b1;
        chk("reset_init_done", {7'd0, init_done}, 8'h00);
        chk("reset_IM", IM, 8'h00);
        chk("reset_model", {7'd0, model_vec() == 43'd0}, 8'h01);

        // single mode with ICW4: WAIT_ICW3 is skipped
        wr(1'b0, 8'h13);
        wr(1'b1, 8'h20);
        chk("icw2_not_done", {7'd0, init_done}, 8'h00);
        wr(1'b1, 8'h03);
        chk("t1_init_done", {7'd0, init_done}, 8'h01);
        chk("t1_vec_base", {3'd0, vec_base}, 8'h04);
        chk("t1_model_vb", {3'd0, m_vb}, 8'h04);
        chk("t1_bits", {4'd0, LTIM, SNGL, AEOI, UPM}, 8'h07);

        // cascade mode, no ICW4: mode bits cleared by ICW1
        wr(1'b0, 8'h18);
        chk("icw1_drop_done", {7'd0, init_done}, 8'h00);
        wr(1'b1, 8'h40);
        wr(1'b1, 8'h04);
        chk("t2_init_done", {7'd0, init_done}, 8'h01);
        chk("t2_mode", {3'd0, SFNM, BUF, MS, AEOI, UPM}, 8'h00);
        chk("t2_ltim", {7'd0, LTIM}, 8'h01);
        chk("t2_icw3", icw3, 8'h04);
        chk("t2_vec_base", {3'd0, vec_base}, 8'h08);

        wr(1'b1, 8'hA5);
        chk("ocw1_IM", IM, 8'hA5);
        wr(1'b0, 8'h20);
        chk("ocw2_stb_1", {7'd0, ocw2_stb}, 8'h01);
        wr(1'b0, 8'h20);
        chk("ocw2_stb_2", {7'd0, ocw2_stb}, 8'h01);
        idle();
        chk("ocw2_stb_off", {7'd0, ocw2_stb}, 8'h00);
        chk("ocw2_operation", operation, 8'h20);

        wr(1'b0, 8'h0B);
        chk("ocw3_risr_smm", {6'd0, read_isr, smm}, 8'h02);
        wr(1'b0, 8'h6C);
        chk("ocw3_poll_smm_risr", {5'd0, poll_stb, smm, read_isr}, 8'h07);
        idle();
        chk("poll_off", {7'd0, poll_stb}, 8'h00);
        chk("ready_IM_kept", IM, 8'hA5);

        // nothing accepted before ICW1
        cyc(1'b1, 1'b0, 1'b0, 8'h00);
        wr(1'b1, 8'hFF);
        wr(1'b0, 8'h20);
        chk("pre_IM", IM, 8'h00);
        chk("pre_op_stb_done", {operation[6:0], ocw2_stb | init_done}, 8'h00);
        idle();

        // reset beats a simultaneous ICW3 write
        wr(1'b0, 8'h10);
        wr(1'b1, 8'h08);
        cyc(1'b1, 1'b1, 1'b1, 8'h04);
        chk("rst_all_zero", {7'd0, dut_vec == 43'd0}, 8'h01);
        wr(1'b1, 8'h55);
        chk("post_rst_icw3", icw3, 8'h00);
        chk("post_rst_IM", IM, 8'h00);

        // ICW1 restart mid-sequence clears partial ICW2
        wr(1'b0, 8'h11);
        wr(1'b1, 8'h28);
        wr(1'b0, 8'h12);
        chk("restart_vb_cleared", {3'd0, vec_base}, 8'h00);
        wr(1'b1, 8'h30);
        chk("restart_done_vb", {init_done, 2'd0, vec_base}, 8'h86);
        wr(1'b0, 8'h08);
        idle();

        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
